xor_share_arbiter: RTL and testbench
====================================

// Module: xor_share_arbiter
//
// PURPOSE
//   Shares one 16-bit bitwise XOR datapath (xorOp instance) between two
//   requesters. Arbitration is round-robin; operands are latched and the
//   result is returned through a valid/ready output channel tagged with the
//   requester ID. Sits between client blocks and the shared XOR unit.
//   Also keeps a count of completed operations.
//
// PARAMETERS
//   WIDTH    16   operand/result width; the datapath is the 16-bit xorOp, so it must stay 16
//   CNT_W    8    width of the completed-operation counter
//
// PORTS
//   clk         in   1      clock, rising edge
//   rst         in   1      synchronous reset, active-high
//   req0_valid  in   1      requester 0 presents operands
//   req0_a      in   WIDTH  requester 0 operand A
//   req0_b      in   WIDTH  requester 0 operand B
//   req0_ready  out  1      requester 0 operands accepted this cycle
//   req1_valid  in   1      requester 1 presents operands
//   req1_a      in   WIDTH  requester 1 operand A
//   req1_b      in   WIDTH  requester 1 operand B
//   req1_ready  out  1      requester 1 operands accepted this cycle
//   res_valid   out  1      result available
//   res_y       out  WIDTH  result = A ^ B of the granted request
//   res_id      out  1      requester that owns res_y (0/1)
//   res_ready   in   1      consumer takes result when res_valid && res_ready
//   op_count    out  CNT_W  number of results consumed, wraps modulo 2^CNT_W
//
// BEHAVIOUR
//   - Reset is synchronous and active-high: rst is sampled on the rising edge of clk.
//   - State machine: IDLE, RESULT. Reset -> IDLE.
//   - Reset values: res_valid=0, res_y=0, res_id=0, op_count=0, prio=0.
//     req*_ready are 0 while rst=1.
//   - prio is the round-robin pointer: the requester favoured on a tie.
//   - IDLE:
//     - If only one reqN_valid=1, grant N.
//     - If both are 1, grant prio.
//     - Grant N drives reqN_ready=1 combinationally in the same cycle. The
//       other ready stays 0. The handshake completes in that cycle.
//     - On the grant edge: latch reqN_a/reqN_b into the operand registers,
//       set res_id=N, set prio=~N, and go to RESULT.
//     - No valid: stay in IDLE. Both readys are 0.
//   - RESULT:
//     - res_valid=1. res_y comes from xorOp driven by the operand registers.
//       res_y and res_id are stable until consumed.
//     - Both req*_ready are 0, so no new grant is made in this state.
//     - When res_ready=1: the handshake completes, op_count increments
//       (255->0 wraps), and the next state is IDLE.
//     - When res_ready=0: hold in RESULT with all outputs unchanged.
//   - Latency: the result is valid on the cycle after the grant cycle.
//     Maximum throughput is 1 result per 2 cycles.
//   - The requester that is not granted must hold its valid and operands.
//     It is served at the next IDLE, because prio then points to it.
//   - rst asserted in any state, including mid-RESULT: the next edge applies
//     the reset values. An unconsumed result is dropped and op_count is
//     not incremented.
//   - reqN_ready never rises while rst=1 or in RESULT.
//
// TESTING
//   1. After reset, req0_valid=1, A=16'hFFFF, B=16'h0F0F, res_ready=1
//      -> req0_ready=1 in cycle 0; next cycle res_valid=1, res_y=16'hF0F0,
//      res_id=0; op_count=1.
//   2. After reset, both valid: req0 (A=16'h1234, B=16'h1234) and
//      req1 (A=16'hAAAA, B=16'h5555)
//      -> req0 is served first with res_y=16'h0000, res_id=0;
//      then req1 with res_y=16'hFFFF, res_id=1; op_count=2.
//   3. Both held valid continuously for 8 cycles, res_ready=1
//      -> grants alternate 0,1,0,1 and readys are never high simultaneously.
//   4. Hold res_ready=0 for 3 cycles in RESULT
//      -> res_valid, res_y and res_id are stable; no reqN_ready pulse;
//      op_count unchanged until res_ready=1.
//   5. Assert rst for 1 cycle while res_valid=1
//      -> res_valid=0, op_count unchanged, prio=0, state IDLE.
//   6. Complete 256 operations
//      -> op_count wraps 8'hFF -> 8'h00 on the 256th consumed result.

Source files
------------

// File: rtl/xor_share_arbiter.sv
// Round-robin sharing of one 16-bit XOR datapath between two requesters.
// Operands are captured on the grant edge; the result is presented on a
// valid/ready channel tagged with the owning requester, and consumed
// results are counted.

module xorOp #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  assign y = a ^ b;

endmodule

module xor_share_arbiter #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_y,
  output logic             res_id,
  input  logic             res_ready,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic {
    IDLE   = 1'b0,
    RESULT = 1'b1
  } state_t;

  state_t           state_p0;
  state_t           state_nxt;
  logic             prio;
  logic             grant0;
  logic             grant1;
  logic [WIDTH-1:0] op_a_p0;
  logic [WIDTH-1:0] op_b_p0;
  logic [WIDTH-1:0] xor_y;
  logic             vld_p0;

  // Round-robin pick: a lone requester wins, a tie goes to prio.
  always_comb begin
    grant0 = req0_valid && (!req1_valid || !prio);
    grant1 = req1_valid && (!req0_valid ||  prio);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_p0 <= IDLE;
    else     state_p0 <= state_nxt;
  end

  // Next-state: leave IDLE on any grant, leave RESULT once the result is taken.
  always_comb begin
    state_nxt = state_p0;
    case (state_p0)
      IDLE:    if (grant0 || grant1) state_nxt = RESULT;
      RESULT:  if (res_ready)        state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: readys only in IDLE outside reset; result visible only in RESULT.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (!rst && state_p0 == IDLE) begin
      req0_ready = grant0;
      req1_ready = grant1;
    end
    vld_p0    = (state_p0 == RESULT);
    res_valid = vld_p0;
    res_y     = vld_p0 ? xor_y : '0;
  end

  // ---- stage p0: operands captured on the grant edge ----

  // Operand registers carry data only, so they are loaded without reset.
  always_ff @(posedge clk) begin
    if (req0_ready) begin
      op_a_p0 <= req0_a;
      op_b_p0 <= req0_b;
    end else if (req1_ready) begin
      op_a_p0 <= req1_a;
      op_b_p0 <= req1_b;
    end
  end

  // Control state: owner tag, round-robin pointer and consumed-result count.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio     <= 1'b0;
      res_id   <= 1'b0;
      op_count <= '0;
    end else begin
      if (req0_ready || req1_ready) begin
        res_id <= req1_ready;
        prio   <= ~req1_ready;
      end
      if (vld_p0 && res_ready) op_count <= op_count + CNT_W'(1);
    end
  end

  xorOp #(
    .WIDTH (WIDTH)
  ) u_xor (
    .a (op_a_p0),
    .b (op_b_p0),
    .y (xor_y)
  );

endmodule

// File: tb/tb_xor_share_arbiter.sv
// Directed bench for xor_share_arbiter with hand-computed expectations.

module tb_xor_share_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid;
  logic [15:0] req0_a;
  logic [15:0] req0_b;
  logic        req0_ready;
  logic        req1_valid;
  logic [15:0] req1_a;
  logic [15:0] req1_b;
  logic        req1_ready;
  logic        res_valid;
  logic [15:0] res_y;
  logic        res_id;
  logic        res_ready;
  logic [7:0]  op_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  xor_share_arbiter #(
    .WIDTH (16),
    .CNT_W (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .res_valid  (res_valid),
    .res_y      (res_y),
    .res_id     (res_id),
    .res_ready  (res_ready),
    .op_count   (op_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock; return 1 time unit after the edge so outputs are settled.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t expected finish earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0;
    res_ready = 1'b0;

    // Reset: readys held low under rst even with a valid request.
    step();
    req0_valid = 1'b1;
    #1;
    check("rst_ready0", req0_ready, 0);
    step();
    req0_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("rst_res_valid", res_valid, 0);
    check("rst_res_y", res_y, 0);
    check("rst_res_id", res_id, 0);
    check("rst_op_count", op_count, 0);

    // 1: single request from requester 0.
    req0_valid = 1'b1; req0_a = 16'hFFFF; req0_b = 16'h0F0F; res_ready = 1'b1;
    #1;
    check("t1_ready0", req0_ready, 1);
    check("t1_ready1", req1_ready, 0);
    step();
    req0_valid = 1'b0;
    check("t1_res_valid", res_valid, 1);
    check("t1_res_y", res_y, 16'hF0F0);
    check("t1_res_id", res_id, 0);
    check("t1_ready0_in_result", req0_ready, 0);
    step();
    check("t1_op_count", op_count, 1);
    check("t1_res_valid_done", res_valid, 0);

    // 2: tie after reset goes to requester 0, then requester 1.
    do_reset();
    req0_valid = 1'b1; req0_a = 16'h1234; req0_b = 16'h1234;
    req1_valid = 1'b1; req1_a = 16'hAAAA; req1_b = 16'h5555;
    #1;
    check("t2_tie_ready0", req0_ready, 1);
    check("t2_tie_ready1", req1_ready, 0);
    step();
    req0_valid = 1'b0;
    check("t2_y0", res_y, 16'h0000);
    check("t2_id0", res_id, 0);
    check("t2_ready1_in_result", req1_ready, 0);
    step();
    check("t2_count1", op_count, 1);
    check("t2_ready1_next", req1_ready, 1);
    step();
    req1_valid = 1'b0;
    check("t2_y1", res_y, 16'hFFFF);
    check("t2_id1", res_id, 1);
    step();
    check("t2_count2", op_count, 2);

    // 3: both valid continuously; grants alternate 0,1,0,1.
    req0_valid = 1'b1; req1_valid = 1'b1; res_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("t3_not_both", {31'd0, req0_ready & req1_ready}, 0);
      if (i % 2 == 0) begin
        check("t3_ready0", req0_ready, (i % 4 == 0) ? 1 : 0);
        check("t3_ready1", req1_ready, (i % 4 == 2) ? 1 : 0);
      end else begin
        check("t3_res_id", res_id, (i % 4 == 3) ? 1 : 0);
        check("t3_res_valid", res_valid, 1);
      end
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("t3_count", op_count, 6);

    // 4: result held under backpressure; waiting requester gets no ready.
    req1_valid = 1'b1; req1_a = 16'h1357; req1_b = 16'h00FF; res_ready = 1'b0;
    #1;
    check("t4_ready1", req1_ready, 1);
    step();
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_a = 16'hDEAD; req0_b = 16'hBEEF;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t4_hold_valid", res_valid, 1);
      check("t4_hold_y", res_y, 16'h13A8);
      check("t4_hold_id", res_id, 1);
      check("t4_hold_ready0", req0_ready, 0);
      check("t4_hold_count", op_count, 6);
      step();
    end
    res_ready = 1'b1;
    req0_valid = 1'b0;
    step();
    check("t4_count", op_count, 7);
    check("t4_res_valid_done", res_valid, 0);

    // 5: reset mid-RESULT drops the result even with res_ready high.
    do_reset();
    req0_valid = 1'b1; req0_a = 16'h00FF; req0_b = 16'hFFFF; res_ready = 1'b0;
    step();
    req0_valid = 1'b0;
    check("t5_res_y", res_y, 16'hFF00);
    rst = 1'b1; res_ready = 1'b1;
    #1;
    check("t5_ready_under_rst", req0_ready, 0);
    step();
    rst = 1'b0;
    check("t5_res_valid", res_valid, 0);
    check("t5_res_y_cleared", res_y, 0);
    check("t5_op_count", op_count, 0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("t5_prio_ready0", req0_ready, 1);
    check("t5_prio_ready1", req1_ready, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;

    // 6: 256 consumed results wrap the counter.
    do_reset();
    req0_valid = 1'b1; req0_a = 16'h0001; req0_b = 16'h0002; res_ready = 1'b1;
    for (int i = 0; i < 255; i++) begin
      step();
      step();
    end
    check("t6_count_ff", op_count, 8'hFF);
    step();
    req0_valid = 1'b0;
    check("t6_res_y", res_y, 16'h0003);
    step();
    check("t6_count_wrap", op_count, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
